// File: rtl/turn_controller_if.sv
// Handshake bundle between the turn controller and the game datapath / game front end.
// The slave modport is the controller; the master modport drives its inputs.
interface turn_controller_if;
    logic       start;
    logic [1:0] num_players;
    logic       flip_valid;
    logic       match;
    logic       win;
    logic       check_req;
    logic       move_req;
    logic       next_turn;
    logic [1:0] cur_player;
    logic       reveal;
    logic       busy;
    logic       game_over;
    logic [1:0] winner;

    modport master (
        output start, num_players, flip_valid, match, win,
        input  check_req, move_req, next_turn, cur_player, reveal, busy, game_over, winner
    );

    modport slave (
        input  start, num_players, flip_valid, match, win,
        output check_req, move_req, next_turn, cur_player, reveal, busy, game_over, winner
    );
endinterface

// File: rtl/turn_controller.sv
// Turn sequencer for the tile-flip race: flip -> check -> move/win or reveal -> pass turn.
// Every output is a flop fed from the next-state logic, so strobes are clean single cycles.
module turn_controller #(
    parameter int unsigned REVEAL_CYCLES = 4,
    parameter int unsigned TURN_TIMEOUT  = 500000000,
    parameter int unsigned TIMER_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    turn_controller_if.slave bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_WAIT, S_CHECK, S_EVAL, S_MOVE, S_WINCHK, S_REVEAL, S_PASS, S_DONE
    } state_t;

    localparam logic [TIMER_W-1:0] RV_LAST = TIMER_W'(REVEAL_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TO_LAST = (TURN_TIMEOUT == 0) ? '0 : TIMER_W'(TURN_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] ONE     = TIMER_W'(1);

    state_t             state, state_d;
    logic [TIMER_W-1:0] counter, counter_d;
    logic [1:0]         last_idx, last_idx_d;   // highest player index of this game
    logic [1:0]         player, player_d;
    logic [1:0]         winner, winner_d;
    logic               check_req, move_req, next_turn, reveal, busy, game_over;

    always_comb begin
        state_d    = state;
        counter_d  = counter;
        last_idx_d = last_idx;
        player_d   = player;
        winner_d   = winner;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d    = S_WAIT;
                    last_idx_d = (bus.num_players == 2'd3) ? 2'd2 : 2'd1;
                    player_d   = 2'd0;
                    counter_d  = '0;
                    winner_d   = 2'd0;
                end
            end
            S_WAIT: begin
                counter_d = counter + ONE;
                // a flip landing on the timeout cycle still counts
                if (bus.flip_valid)
                    state_d = S_CHECK;
                else if (TURN_TIMEOUT != 0 && counter == TO_LAST)
                    state_d = S_PASS;
            end
            S_CHECK: state_d = S_EVAL;
            S_EVAL: begin
                if (bus.match) begin
                    state_d = S_MOVE;
                end else begin
                    state_d   = S_REVEAL;
                    counter_d = '0;
                end
            end
            S_MOVE: state_d = S_WINCHK;
            S_WINCHK: begin
                if (bus.win) begin
                    state_d  = S_DONE;
                    winner_d = player;
                end else begin
                    state_d   = S_WAIT;
                    counter_d = '0;
                end
            end
            S_REVEAL: begin
                counter_d = counter + ONE;
                if (counter == RV_LAST)
                    state_d = S_PASS;
            end
            S_PASS: begin
                player_d  = (player == last_idx) ? 2'd0 : player + 2'd1;
                state_d   = S_WAIT;
                counter_d = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            counter   <= '0;
            last_idx  <= 2'd1;
            player    <= 2'd0;
            winner    <= 2'd0;
            check_req <= 1'b0;
            move_req  <= 1'b0;
            next_turn <= 1'b0;
            reveal    <= 1'b0;
            busy      <= 1'b0;
            game_over <= 1'b0;
        end else begin
            state     <= state_d;
            counter   <= counter_d;
            last_idx  <= last_idx_d;
            player    <= player_d;
            winner    <= winner_d;
            check_req <= (state_d == S_CHECK);
            move_req  <= (state_d == S_MOVE);
            next_turn <= (state_d == S_PASS);
            reveal    <= (state_d == S_REVEAL);
            busy      <= !(state_d inside {S_IDLE, S_DONE});
            game_over <= (state_d == S_DONE);
        end
    end

    assign bus.check_req  = check_req;
    assign bus.move_req   = move_req;
    assign bus.next_turn  = next_turn;
    assign bus.cur_player = player;
    assign bus.reveal     = reveal;
    assign bus.busy       = busy;
    assign bus.game_over  = game_over;
    assign bus.winner     = winner;
endmodule
